axil_wr_monitor: RTL
====================

# axil_wr_monitor

Synthesizable, parametrised AXI-Lite write-path protocol monitor covering the AW, W and B channels. It generalises the write-address assertion checker into hardware that can run in simulation, emulation or silicon debug. It tracks per-channel handshake stability, per-channel ready/valid timeouts, reset-exit VALID rules and AW/W-versus-B outstanding accounting. Violations are reported as registered sticky flags, one-cycle pulses and a saturating counter. The block sits passively beside any AXI-Lite master/slave pair and drives nothing on the bus.

## Interface
- C_AXI_ADDR_WIDTH, 8, AWADDR width
- C_AXI_DATA_WIDTH, 32, WDATA width; WSTRB is C_AXI_DATA_WIDTH/8
- MAXWAIT, 5, max cycles after first stalled cycle for READY (>=1)
- MAX_OUTSTANDING, 4, max accepted-but-unresponded AW (and W) transfers (>=1)
- ERR_CNT_WIDTH, 8, width of error counter
- AXI_ACLK  in  1  clock, rising edge
- AXI_ARESETN  in  1  asynchronous active-low reset
- AXI_AWADDR  in  C_AXI_ADDR_WIDTH; AXI_AWVALID, AXI_AWREADY  in  1
- AXI_WDATA  in  C_AXI_DATA_WIDTH; AXI_WSTRB  in  C_AXI_DATA_WIDTH/8; AXI_WVALID, AXI_WREADY  in  1
- AXI_BRESP  in  2; AXI_BVALID, AXI_BREADY  in  1
- err_clear  in  1  synchronous clear of err_sticky and err_count
- err_sticky  out  9  latched violation flags
- err_pulse  out  9  one-cycle flag per newly detected violation
- err_count  out  ERR_CNT_WIDTH  saturating count of detected violations
- aw_outstanding, w_outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted AW/W not yet matched by B

## Operation
- Error bits: 0 AW_STABLE, 1 W_STABLE, 2 B_STABLE, 3 AW_TIMEOUT, 4 W_TIMEOUT, 5 B_TIMEOUT, 6 B_ORPHAN, 7 OVERFLOW, 8 VALID_RESET.
- Handshake on a channel = VALID & READY at a rising edge. Stall = VALID & !READY.
- Stability, per channel:
  - Registered copies of VALID, READY and payload are kept (AW: AWADDR; W: WDATA+WSTRB; B: BRESP).
  - If the previous edge was a stall and at this edge VALID=0 or the payload differs, the channel's STABLE bit is raised.
- Timeout, per channel:
  - wait_cnt counts consecutive prior stall edges and saturates at MAXWAIT. It clears to 0 on any non-stall edge.
  - When a stall occurs with wait_cnt==MAXWAIT, the TIMEOUT bit is raised once per stall episode.
  - "Once per episode" is implemented with a fired flag, cleared when the stall ends.
- VALID_RESET: the first edge after AXI_ARESETN deasserts is tracked by a registered flag. If AWVALID, WVALID or BVALID is high at that edge, bit 8 is raised.
- Outstanding accounting:
  - aw_outstanding increments on an AW handshake and decrements on a B handshake; w_outstanding likewise for W.
  - B handshake with aw_outstanding==0 or w_outstanding==0: raise B_ORPHAN; neither counter decrements.
  - AW (or W) handshake with its counter ==MAX_OUTSTANDING and no valid decrementing B the same edge: raise OVERFLOW; the counter holds.
  - Simultaneous increment and valid decrement: the counter is unchanged.
- Reporting:
  - err_pulse[i] = detection at the previous edge.
  - err_sticky |= err_pulse.
  - err_count adds popcount(new detections) and saturates at all-ones.
  - err_clear zeroes err_sticky and err_count. Detections at the same edge still set: the new value is the pulse vector and its popcount.

## Timing
- Reset (async, AXI_ARESETN=0): all outputs 0; all counters, history registers and fired flags 0.
- Violation sampled at edge t: err_pulse/err_sticky/err_count update at edge t+1 (1-cycle latency).
- Stability check is suppressed at the first edge after reset, because history registers are reset to 0.
- Reset asserted mid-transaction clears the outstanding counts immediately. Nothing is flagged for the lost transactions.
- Counters use modular-free saturating arithmetic only; no wrap-around on any output.

## Test plan
- AWVALID=1, AWREADY=0, AWADDR=0x10 for 3 edges, then AWADDR=0x14 -> err_pulse=0x001 one cycle later, err_sticky=0x001, err_count=1.
- MAXWAIT=5, WVALID=1, WREADY=0 for 6 consecutive edges -> single pulse bit 4 after 6th edge. 10 further stall edges -> no additional pulse, err_count=1.
- Two AW and two W handshakes, then two B handshakes -> outstanding 2 then 0, no errors. Third B -> B_ORPHAN (0x040), counters stay 0.
- MAX_OUTSTANDING=4, five AW handshakes without B -> OVERFLOW on 5th, aw_outstanding=4. AW handshake plus B handshake same edge at 4 -> no error, stays 4.
- Release reset with BVALID=1 -> err_pulse=0x100. Assert err_clear together with a new AW_STABLE violation -> err_sticky=0x001, err_count=1.
- Force 300 violations with ERR_CNT_WIDTH=8 -> err_count holds 255. Assert AXI_ARESETN=0 mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/axil_wr_monitor.sv
// Passive AXI-Lite write-path (AW/W/B) protocol monitor.
// It checks handshake stability, stall timeouts, VALID at reset exit and outstanding accounting.
module axil_wr_monitor #(
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MAXWAIT          = 5,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int ERR_CNT_WIDTH    = 8
) (
    input  logic                                 AXI_ACLK,
    input  logic                                 AXI_ARESETN,
    input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
    input  logic                                 AXI_AWVALID,
    input  logic                                 AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]          AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]        AXI_WSTRB,
    input  logic                                 AXI_WVALID,
    input  logic                                 AXI_WREADY,
    input  logic [1:0]                           AXI_BRESP,
    input  logic                                 AXI_BVALID,
    input  logic                                 AXI_BREADY,
    input  logic                                 err_clear,
    output logic [8:0]                           err_sticky,
    output logic [8:0]                           err_pulse,
    output logic [ERR_CNT_WIDTH-1:0]             err_count,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] aw_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] w_outstanding
);
    localparam int CW = $clog2(MAX_OUTSTANDING+1);
    localparam int WW = $clog2(MAXWAIT+1);
    localparam int SW = ERR_CNT_WIDTH + 4;
    localparam int PW = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH/8;

    // Channel index: 0 = AW, 1 = W, 2 = B
    logic [2:0]                  valid, ready, stall, prev_stall, changed;
    logic [2:0]                  valid_q, ready_q, fired;
    logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [PW-1:0]               wpay_q;
    logic [1:0]                  bresp_q;
    logic [WW-1:0]               wait_cnt [3];
    logic                        seen_edge;

    logic          aw_hs, w_hs, b_hs, orphan, b_dec, aw_ovf, w_ovf;
    logic [CW-1:0] aw_next, w_next;
    logic [8:0]    det;
    logic [SW-1:0] cnt_base, cnt_sum;
    logic [ERR_CNT_WIDTH-1:0] cnt_next;

    assign valid      = {AXI_BVALID, AXI_WVALID, AXI_AWVALID};
    assign ready      = {AXI_BREADY, AXI_WREADY, AXI_AWREADY};
    assign stall      = valid & ~ready;
    assign prev_stall = valid_q & ~ready_q;
    assign changed[0] = (AXI_AWADDR != awaddr_q);
    assign changed[1] = ({AXI_WDATA, AXI_WSTRB} != wpay_q);
    assign changed[2] = (AXI_BRESP != bresp_q);

    assign aw_hs  = AXI_AWVALID & AXI_AWREADY;
    assign w_hs   = AXI_WVALID & AXI_WREADY;
    assign b_hs   = AXI_BVALID & AXI_BREADY;
    // A B response only retires a write once both its AW and W have been accepted
    assign orphan = b_hs & ((aw_outstanding == '0) | (w_outstanding == '0));
    assign b_dec  = b_hs & ~orphan;

    always_comb begin
        aw_next = aw_outstanding;
        aw_ovf  = 1'b0;
        if (aw_hs && !b_dec) begin
            if (aw_outstanding == CW'(MAX_OUTSTANDING)) aw_ovf = 1'b1;
            else aw_next = aw_outstanding + CW'(1);
        end else if (!aw_hs && b_dec) begin
            aw_next = aw_outstanding - CW'(1);
        end
    end

    always_comb begin
        w_next = w_outstanding;
        w_ovf  = 1'b0;
        if (w_hs && !b_dec) begin
            if (w_outstanding == CW'(MAX_OUTSTANDING)) w_ovf = 1'b1;
            else w_next = w_outstanding + CW'(1);
        end else if (!w_hs && b_dec) begin
            w_next = w_outstanding - CW'(1);
        end
    end

    always_comb begin
        det = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            det[i]   = prev_stall[i] & (~valid[i] | changed[i]);
            det[3+i] = stall[i] & (wait_cnt[i] == WW'(MAXWAIT)) & ~fired[i];
        end
        det[6] = orphan;
        det[7] = aw_ovf | w_ovf;
        det[8] = ~seen_edge & (|valid);
    end

    always_comb begin
        cnt_base = err_clear ? '0 : SW'(err_count);
        cnt_sum  = cnt_base + SW'($countones(det));
        cnt_next = (cnt_sum > SW'({ERR_CNT_WIDTH{1'b1}})) ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            valid_q        <= '0;
            ready_q        <= '0;
            awaddr_q       <= '0;
            wpay_q         <= '0;
            bresp_q        <= '0;
            for (int unsigned i = 0; i < 3; i++) wait_cnt[i] <= '0;
            fired          <= '0;
            seen_edge      <= 1'b0;
            aw_outstanding <= '0;
            w_outstanding  <= '0;
            err_pulse      <= '0;
            err_sticky     <= '0;
            err_count      <= '0;
        end else begin
            valid_q   <= valid;
            ready_q   <= ready;
            awaddr_q  <= AXI_AWADDR;
            wpay_q    <= {AXI_WDATA, AXI_WSTRB};
            bresp_q   <= AXI_BRESP;
            seen_edge <= 1'b1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (stall[i]) begin
                    if (wait_cnt[i] != WW'(MAXWAIT)) wait_cnt[i] <= wait_cnt[i] + WW'(1);
                    if (wait_cnt[i] == WW'(MAXWAIT)) fired[i] <= 1'b1;
                end else begin
                    wait_cnt[i] <= '0;
                    fired[i]    <= 1'b0;
                end
            end
            aw_outstanding <= aw_next;
            w_outstanding  <= w_next;
            err_pulse      <= det;
            err_sticky     <= err_clear ? det : (err_sticky | det);
            err_count      <= cnt_next;
        end
    end
endmodule
